// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle processor control unit: state encoding,
// opcode map, datapath mux selects and the decoded control word.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    ADDI_WB   = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ILLEGAL   = 4'd11,
    HALT      = 4'd12
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_J    = 3'b101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       alu_src_a;
    logic       instr_done;
    logic       illegal_op;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/control_output_decode.sv
// Moore output decode: maps the current state onto the full datapath control word.
module control_output_decode
  import ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_TWO;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        // Taken/not-taken is resolved in the datapath by Zero gating PCWriteCond.
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      HALT:    ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the 16-bit multi-cycle datapath: state register,
// next-state sequencing, reset override of outputs and retired-instruction counter.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       opcode,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             RegWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             ALUSrcA,
  output logic [3:0]       state_dbg,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  ctrl_t  dec, ctrl;

  control_output_decode u_decode (
    .state (state),
    .ctrl  (dec)
  );

  // Reset silences the datapath immediately, even mid-instruction.
  assign ctrl = reset ? '0 : dec;

  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IorD        = ctrl.i_or_d;
  assign RegWrite    = ctrl.reg_write;
  assign IRWrite     = ctrl.ir_write;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;
  assign halted      = ctrl.halted;
  assign state_dbg   = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      if (dec.instr_done) instr_count <= instr_count + 1'b1;
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_R:                    state <= R_EXEC;
            OP_ADDI, OP_LW, OP_SW:   state <= MEM_ADDR;
            OP_BEQ:                  state <= BRANCH;
            OP_J:                    state <= JUMP;
            default:                 state <= ILLEGAL;
          endcase
        end
        // IR is frozen outside FETCH, so re-reading opcode here is safe.
        MEM_ADDR: begin
          case (opcode)
            OP_LW:   state <= MEM_READ;
            OP_SW:   state <= MEM_WRITE;
            default: state <= ADDI_WB;
          endcase
        end
        MEM_READ:  state <= MEM_WB;
        R_EXEC:    state <= R_WB;
        ILLEGAL:   state <= ILLEGAL_HALT ? HALT : FETCH;
        HALT:      state <= HALT;
        default:   state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-opcode state-sequence table plus per-state control
// table, random instruction streams, reset abort, illegal halt and counter wrap.
module tb_multicycle_control_fsm;

  logic clock = 1'b0;
  logic ra = 1'b1, rb = 1'b1;
  logic [2:0] opcode = 3'b000;
  always #5 clock = ~clock;

  logic [1:0] aop_a, srcb_a, pcs_a, aop_b, srcb_b, pcs_b;
  logic rd_a, m2r_a, mr_a, mw_a, iod_a, rw_a, irw_a, pcw_a, pcwc_a, sa_a, dn_a, il_a, h_a;
  logic rd_b, m2r_b, mr_b, mw_b, iod_b, rw_b, irw_b, pcw_b, pcwc_b, sa_b, dn_b, il_b, h_b;
  logic [3:0]  st_a, st_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  multicycle_control_fsm u_a (
    .clock(clock), .reset(ra), .opcode(opcode),
    .ALUOp(aop_a), .ALUSrcB(srcb_a), .PCSource(pcs_a),
    .RegDst(rd_a), .MemtoReg(m2r_a), .MemRead(mr_a), .MemWrite(mw_a), .IorD(iod_a),
    .RegWrite(rw_a), .IRWrite(irw_a), .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .ALUSrcA(sa_a),
    .state_dbg(st_a), .instr_done(dn_a), .illegal_op(il_a), .halted(h_a), .instr_count(cnt_a)
  );

  multicycle_control_fsm #(.ILLEGAL_HALT(1'b1), .CNT_W(4)) u_b (
    .clock(clock), .reset(rb), .opcode(opcode),
    .ALUOp(aop_b), .ALUSrcB(srcb_b), .PCSource(pcs_b),
    .RegDst(rd_b), .MemtoReg(m2r_b), .MemRead(mr_b), .MemWrite(mw_b), .IorD(iod_b),
    .RegWrite(rw_b), .IRWrite(irw_b), .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .ALUSrcA(sa_b),
    .state_dbg(st_b), .instr_done(dn_b), .illegal_op(il_b), .halted(h_b), .instr_count(cnt_b)
  );

  logic [18:0] wa, wb;
  assign wa = {aop_a, srcb_a, pcs_a, rd_a, m2r_a, mr_a, mw_a, iod_a, rw_a, irw_a, pcw_a, pcwc_a, sa_a, dn_a, il_a, h_a};
  assign wb = {aop_b, srcb_b, pcs_b, rd_b, m2r_b, mr_b, mw_b, iod_b, rw_b, irw_b, pcw_b, pcwc_b, sa_b, dn_b, il_b, h_b};

  int tests = 0, fails = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags: RegDst MemtoReg MemRead MemWrite IorD RegWrite IRWrite PCWrite PCWriteCond ALUSrcA done illegal halted
  function automatic logic [18:0] cw(input logic [1:0] aop, input logic [1:0] srcb,
                                     input logic [1:0] pcs, input logic [12:0] f);
    return {aop, srcb, pcs, f};
  endfunction

  typedef struct {
    logic [2:0]      op;
    int              lat;
    logic [4:0][3:0] seq;  // seq[0] is the first (FETCH) cycle
  } vec_t;

  logic [18:0] ctrl_exp [13];
  vec_t        vecs [8];
  int          mcnt_a = 0, mcnt_b = 0;

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Runs one instruction starting in FETCH; checks every cycle against the tables.
  task automatic run_instr(input bit b, input logic [2:0] op);
    vec_t v;
    v = vecs[op];
    opcode = op;
    for (int i = 0; i < v.lat; i++) begin
      #1;
      chk(b ? "state_b" : "state_a", b ? 32'(st_b) : 32'(st_a), 32'(v.seq[i]));
      chk(b ? "ctrl_b" : "ctrl_a", b ? 32'(wb) : 32'(wa), 32'(ctrl_exp[v.seq[i]]));
      step();
    end
    if (b) begin
      mcnt_b = (mcnt_b + 1) % 16;
      chk("count_b", 32'(cnt_b), 32'(mcnt_b));
    end else begin
      mcnt_a = (mcnt_a + 1) % 65536;
      chk("count_a", 32'(cnt_a), 32'(mcnt_a));
    end
  endtask

  always @(negedge clock) if (mon_en) begin
    chk("inv_mem_a", 32'(mr_a & mw_a), 0);
    chk("inv_pc_a",  32'(pcw_a & pcwc_a), 0);
    chk("inv_mem_b", 32'(mr_b & mw_b), 0);
    chk("inv_pc_b",  32'(pcw_b & pcwc_b), 0);
  end

  initial begin
    ctrl_exp[0]  = cw(2'b00, 2'b01, 2'b00, 13'b0010001100000);
    ctrl_exp[1]  = cw(2'b00, 2'b11, 2'b00, 13'b0000000000000);
    ctrl_exp[2]  = cw(2'b00, 2'b10, 2'b00, 13'b0000000001000);
    ctrl_exp[3]  = cw(2'b00, 2'b00, 2'b00, 13'b0010100000000);
    ctrl_exp[4]  = cw(2'b00, 2'b00, 2'b00, 13'b0100010000100);
    ctrl_exp[5]  = cw(2'b00, 2'b00, 2'b00, 13'b0001100000100);
    ctrl_exp[6]  = cw(2'b10, 2'b00, 2'b00, 13'b0000000001000);
    ctrl_exp[7]  = cw(2'b00, 2'b00, 2'b00, 13'b1000010000100);
    ctrl_exp[8]  = cw(2'b00, 2'b00, 2'b00, 13'b0000010000100);
    ctrl_exp[9]  = cw(2'b01, 2'b00, 2'b01, 13'b0000000011100);
    ctrl_exp[10] = cw(2'b00, 2'b00, 2'b10, 13'b0000000100100);
    ctrl_exp[11] = cw(2'b00, 2'b00, 2'b00, 13'b0000000000110);
    ctrl_exp[12] = cw(2'b00, 2'b00, 2'b00, 13'b0000000000001);

    vecs[0] = '{3'b000, 4, {4'd0, 4'd7,  4'd6, 4'd1, 4'd0}};
    vecs[1] = '{3'b001, 4, {4'd0, 4'd8,  4'd2, 4'd1, 4'd0}};
    vecs[2] = '{3'b010, 5, {4'd4, 4'd3,  4'd2, 4'd1, 4'd0}};
    vecs[3] = '{3'b011, 4, {4'd0, 4'd5,  4'd2, 4'd1, 4'd0}};
    vecs[4] = '{3'b100, 3, {4'd0, 4'd0,  4'd9, 4'd1, 4'd0}};
    vecs[5] = '{3'b101, 3, {4'd0, 4'd0, 4'd10, 4'd1, 4'd0}};
    vecs[6] = '{3'b110, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0}};
    vecs[7] = '{3'b111, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0}};

    // Reset held two cycles: outputs silent, then FETCH with a cleared counter.
    ra = 1'b1; rb = 1'b1; opcode = 3'b000;
    step(); #1; chk("rst_ctrl0", 32'(wa), 0);
    step(); #1; chk("rst_ctrl1", 32'(wa), 0);
    mon_en = 1'b1;
    ra = 1'b0; #1;
    chk("rst_state", 32'(st_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    mcnt_a = 0;

    for (int i = 0; i < 8; i++) run_instr(1'b0, vecs[i].op);

    for (int i = 0; i < 40; i++) run_instr(1'b0, 3'($urandom_range(0, 7)));

    // Reset arriving in MEM_READ of a load aborts it without a register write.
    opcode = 3'b010;
    step(); step(); step();
    chk("abort_in_memread", 32'(st_a), 3);
    ra = 1'b1; #1;
    chk("abort_ctrl_now", 32'(wa), 0);
    step(); #1;
    chk("abort_ctrl_next", 32'(wa), 0);
    chk("abort_state", 32'(st_a), 0);
    chk("abort_count", 32'(cnt_a), 0);
    ra = 1'b0; mcnt_a = 0; #1;
    chk("abort_fetch", 32'(wa), 32'(ctrl_exp[0]));
    run_instr(1'b0, 3'b001);

    // Halting variant: illegal opcode parks in HALT until reset.
    rb = 1'b0; opcode = 3'b110; mcnt_b = 0;
    #1; chk("b_fetch", 32'(st_b), 0);
    step(); step(); #1;
    chk("b_illegal_state", 32'(st_b), 11);
    chk("b_illegal_ctrl", 32'(wb), 32'(ctrl_exp[11]));
    opcode = 3'b000;
    for (int i = 0; i < 22; i++) begin
      step(); #1;
      chk("b_halt_state", 32'(st_b), 12);
      chk("b_halt_ctrl", 32'(wb), 32'(ctrl_exp[12]));
    end
    chk("b_halt_count", 32'(cnt_b), 1);
    rb = 1'b1; step(); rb = 1'b0; #1;
    chk("b_unhalt_state", 32'(st_b), 0);
    chk("b_unhalt_count", 32'(cnt_b), 0);
    mcnt_b = 0;

    // 4-bit counter wraps after sixteen jumps.
    for (int i = 0; i < 16; i++) run_instr(1'b1, 3'b101);
    chk("b_wrap", 32'(cnt_b), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
